// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C definitions for the temperature sensor slave and i2c_master.
// Contents: slave FSM state enum, bus condition enum, ACK/NACK and R/W bit levels,
// and an address compare helper.
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK, RX_BYTE, WR_ACK, WAIT_STOP
    } i2c_state_t;
    typedef enum logic [1:0] {BUS_NONE, BUS_START, BUS_STOP} bus_cond_t;
    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;
    function automatic logic addr_match(input logic [6:0] a, input logic [6:0] b);
        return a == b;
    endfunction
endpackage

// File: rtl/i2c_temp_sensor_slave_if.sv
// i2c_temp_sensor_slave_if: I2C pad-side signals of the temperature sensor slave.
// scl_in/sda_in: raw pad levels; sda_oe: open-drain enable (1 = pull SDA low).
interface i2c_temp_sensor_slave_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;
    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes raw SCL/SDA and detects SCL edges and START/STOP.
// Ports: clk, rst (async active-low), scl_raw/sda_raw in; sda (synced),
// scl_rise/scl_fall one-cycle pulses, cond (START/STOP pulse) out.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      scl_raw,
    input  logic      sda_raw,
    output logic      sda,
    output logic      scl_rise,
    output logic      scl_fall,
    output bus_cond_t cond
);
    logic [STAGES-1:0] scl_sr, sda_sr;
    logic scl, scl_d, sda_d;
    // Idle bus level is high, so flops reset to 1 to avoid fake edges on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sr <= (scl_sr << 1) | STAGES'(scl_raw);
            sda_sr <= (sda_sr << 1) | STAGES'(sda_raw);
            scl_d  <= scl;
            sda_d  <= sda;
        end
    end
    assign scl      = scl_sr[STAGES-1];
    assign sda      = sda_sr[STAGES-1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign cond     = (scl && scl_d && sda_d && !sda) ? BUS_START :
                      (scl && scl_d && !sda_d && sda) ? BUS_STOP : BUS_NONE;
endmodule

// File: rtl/i2c_temp_sensor_slave.sv
// i2c_temp_sensor_slave: I2C slave returning a 16-bit temperature register on reads.
// Ports: clk, rst (async active-low), bus (scl_in/sda_in/sda_oe), temp_data in;
// busy, rd_done, wr_data, wr_stb out.
// Macro I2C_SLAVE_WRITE_EN enables master writes (ACKed, stored to wr_data, pulsed on wr_stb).
module i2c_temp_sensor_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h4B,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    i2c_temp_sensor_slave_if.slave  bus,
    input  logic [15:0]             temp_data,
    output logic                    busy,
    output logic                    rd_done,
    output logic [7:0]              wr_data,
    output logic                    wr_stb
);
`ifdef I2C_SLAVE_WRITE_EN
    localparam logic WRITE_EN = 1'b1;
`else
    localparam logic WRITE_EN = 1'b0;
`endif
    logic sda, scl_rise, scl_fall;
    bus_cond_t cond;
    i2c_state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sr, sr_n, tx, tx_n, nxt_byte, wr_data_n;
    logic [15:0] shadow, shadow_n;
    logic sel, sel_n, oe, oe_n, busy_n, rd_done_n, wr_stb_n;

    i2c_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_raw  (bus.scl_in),
        .sda_raw  (bus.sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .cond     (cond)
    );

    assign bus.sda_oe = oe;
    // After byte 2 the read wraps back to the high byte of the same shadow.
    assign nxt_byte = sel ? shadow[15:8] : shadow[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            tx      <= '0;
            shadow  <= '0;
            sel     <= 1'b0;
            oe      <= 1'b0;
            busy    <= 1'b0;
            rd_done <= 1'b0;
            wr_data <= '0;
            wr_stb  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sr      <= sr_n;
            tx      <= tx_n;
            shadow  <= shadow_n;
            sel     <= sel_n;
            oe      <= oe_n;
            busy    <= busy_n;
            rd_done <= rd_done_n;
            wr_data <= wr_data_n;
            wr_stb  <= wr_stb_n;
        end
    end

    // sda_oe only changes on scl_fall cycles (or START/STOP, where it is already released).
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        tx_n      = tx;
        shadow_n  = shadow;
        sel_n     = sel;
        oe_n      = oe;
        busy_n    = busy;
        rd_done_n = 1'b0;
        wr_data_n = wr_data;
        wr_stb_n  = 1'b0;
        if (cond == BUS_STOP) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (cond == BUS_START) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sr_n  = {sr[6:0], sda};
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        if (addr_match(sr[7:1], DEV_ADDR) && (sr[0] == RW_READ || WRITE_EN)) begin
                            state_n  = ADDR_ACK;
                            oe_n     = 1'b1;
                            busy_n   = 1'b1;
                            shadow_n = sr[0] ? temp_data : shadow;
                        end else begin
                            state_n = WAIT_STOP;
                            busy_n  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n   = '0;
                        sel_n   = 1'b0;
                        tx_n    = shadow[15:8];
                        state_n = sr[0] ? TX_BYTE : RX_BYTE;
                        oe_n    = sr[0] ? ~shadow[15] : 1'b0;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        if (cnt == 4'd7) begin
                            state_n = RX_ACK;
                            oe_n    = 1'b0;
                        end else begin
                            cnt_n = cnt + 4'd1;
                            tx_n  = tx << 1;
                            oe_n  = ~tx[6];
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_rise && sda == NACK) begin
                        state_n   = WAIT_STOP;
                        rd_done_n = 1'b1;
                        oe_n      = 1'b0;
                    end else if (scl_fall) begin
                        state_n = TX_BYTE;
                        cnt_n   = '0;
                        sel_n   = ~sel;
                        tx_n    = nxt_byte;
                        oe_n    = ~nxt_byte[7];
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        sr_n  = {sr[6:0], sda};
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        state_n   = WR_ACK;
                        oe_n      = 1'b1;
                        wr_data_n = sr;
                        wr_stb_n  = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_n = RX_BYTE;
                        cnt_n   = '0;
                        oe_n    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_temp_sensor_slave.sv
// tb_i2c_temp_sensor_slave: directed bench driving an I2C master model against the slave.
module tb_i2c_temp_sensor_slave;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic [15:0] temp_data = 16'h1A80;
    logic busy, rd_done, wr_stb;
    logic [7:0] wr_data;
    int total = 0, passed = 0, failed = 0;
    int oe_cyc = 0, busy_cyc = 0, rd_cnt = 0, wr_cnt = 0, oe_hi_chg = 0;
    logic prev_oe = 1'b0;

    i2c_temp_sensor_slave_if bus ();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_temp_sensor_slave dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .temp_data (temp_data),
        .busy      (busy),
        .rd_done   (rd_done),
        .wr_data   (wr_data),
        .wr_stb    (wr_stb)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sda_oe) oe_cyc++;
        if (busy) busy_cyc++;
        if (rd_done) rd_cnt++;
        if (wr_stb) wr_cnt++;
        if (rst && scl_m && bus.sda_oe !== prev_oe) oe_hi_chg++;
        prev_oe = bus.sda_oe;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (10) @(negedge clk);
    endtask

    task automatic start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; q();
        scl_m = 1'b1; q();
        scl_m = 1'b0; q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = ~bus.sda_oe;
        scl_m = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ackb, input int chg_at, input logic [15:0] chg_val,
                             output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == chg_at) temp_data = chg_val;
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(ackb);
    endtask

    initial begin
        logic ack;
        logic b;
        logic [7:0] d;
        int rd0, oe0, busy0, wr0;
        repeat (5) @(negedge clk);
        check("rst_sda_oe", 16'(bus.sda_oe), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_rd_done", 16'(rd_done), 16'h0);
        check("rst_wr_stb", 16'(wr_stb), 16'h0);
        check("rst_wr_data", 16'(wr_data), 16'h0);
        rst = 1'b1;
        q();

        // plain read: ACK after byte 1, NACK after byte 2
        rd0 = rd_cnt;
        temp_data = 16'h1A80;
        start();
        write_byte({7'h4B, 1'b1}, ack);
        check("rd_addr_ack", 16'(ack), 16'h0);
        check("rd_busy", 16'(busy), 16'h1);
        read_byte(1'b0, -1, 16'h0, d);
        check("rd_byte1", 16'(d), 16'h1A);
        read_byte(1'b1, -1, 16'h0, d);
        check("rd_byte2", 16'(d), 16'h80);
        stop();
        q();
        check("rd_busy_after_stop", 16'(busy), 16'h0);
        check("rd_done_count", 16'(rd_cnt - rd0), 16'h1);

        // wrong address: slave must stay off the bus
        rd0 = rd_cnt; oe0 = oe_cyc; busy0 = busy_cyc;
        start();
        write_byte({7'h48, 1'b1}, ack);
        check("miss_addr_nack", 16'(ack), 16'h1);
        read_byte(1'b1, -1, 16'h0, d);
        check("miss_byte", 16'(d), 16'hFF);
        stop();
        q();
        check("miss_oe_cycles", 16'(oe_cyc - oe0), 16'h0);
        check("miss_busy_cycles", 16'(busy_cyc - busy0), 16'h0);
        check("miss_rd_done", 16'(rd_cnt - rd0), 16'h0);

        // temp_data changes mid byte 1; third byte wraps to the latched high byte
        rd0 = rd_cnt;
        temp_data = 16'h1A80;
        start();
        write_byte({7'h4B, 1'b1}, ack);
        check("shadow_addr_ack", 16'(ack), 16'h0);
        read_byte(1'b0, 4, 16'h2000, d);
        check("shadow_byte1", 16'(d), 16'h1A);
        read_byte(1'b0, -1, 16'h0, d);
        check("shadow_byte2", 16'(d), 16'h80);
        read_byte(1'b1, -1, 16'h0, d);
        check("shadow_byte3_wrap", 16'(d), 16'h1A);
        stop();
        q();
        check("shadow_rd_done", 16'(rd_cnt - rd0), 16'h1);

        // reset asserted in byte 2 while the slave drives a 0 bit
        temp_data = 16'h1A80;
        start();
        write_byte({7'h4B, 1'b1}, ack);
        check("rst_mid_addr_ack", 16'(ack), 16'h0);
        read_byte(1'b0, -1, 16'h0, d);
        check("rst_mid_byte1", 16'(d), 16'h1A);
        for (int i = 0; i < 3; i++) read_bit(b);
        check("rst_mid_driving", 16'(bus.sda_oe), 16'h1);
        rst = 1'b0;
        #1;
        check("rst_mid_release", 16'(bus.sda_oe), 16'h0);
        check("rst_mid_busy", 16'(busy), 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q();
        rd0 = rd_cnt;
        temp_data = 16'h3C55;
        start();
        write_byte({7'h4B, 1'b1}, ack);
        check("post_rst_addr_ack", 16'(ack), 16'h0);
        read_byte(1'b0, -1, 16'h0, d);
        check("post_rst_byte1", 16'(d), 16'h3C);
        read_byte(1'b1, -1, 16'h0, d);
        check("post_rst_byte2", 16'(d), 16'h55);
        stop();
        q();
        check("post_rst_rd_done", 16'(rd_cnt - rd0), 16'h1);

        // write 8'h5C
        wr0 = wr_cnt;
        start();
        write_byte({7'h4B, 1'b0}, ack);
`ifdef I2C_SLAVE_WRITE_EN
        check("wr_addr_ack", 16'(ack), 16'h0);
        write_byte(8'h5C, ack);
        check("wr_data_ack", 16'(ack), 16'h0);
        stop();
        q();
        check("wr_data", 16'(wr_data), 16'h5C);
        check("wr_stb_count", 16'(wr_cnt - wr0), 16'h1);
`else
        check("wr_addr_nack", 16'(ack), 16'h1);
        write_byte(8'h5C, ack);
        check("wr_data_nack", 16'(ack), 16'h1);
        stop();
        q();
        check("wr_data_held", 16'(wr_data), 16'h0);
        check("wr_stb_count", 16'(wr_cnt - wr0), 16'h0);
`endif

        // repeated START after address ACK (first data bit is a released 1)
        rd0 = rd_cnt;
        temp_data = 16'hA5C3;
        start();
        write_byte({7'h4B, 1'b1}, ack);
        check("rs_addr1_ack", 16'(ack), 16'h0);
        temp_data = 16'h1A80;
        start();
        write_byte({7'h4B, 1'b1}, ack);
        check("rs_addr2_ack", 16'(ack), 16'h0);
        read_byte(1'b0, -1, 16'h0, d);
        check("rs_byte1", 16'(d), 16'h1A);
        read_byte(1'b1, -1, 16'h0, d);
        check("rs_byte2", 16'(d), 16'h80);
        stop();
        q();
        check("rs_rd_done", 16'(rd_cnt - rd0), 16'h1);
        check("rs_busy_after_stop", 16'(busy), 16'h0);

        check("oe_change_scl_high", 16'(oe_hi_chg), 16'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_temp_sensor_slave.md
I2C_TEMP_SENSOR_SLAVE -- requirements
Module: i2c_temp_sensor_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h4B, the 7-bit I2C device address it responds to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on scl_in/sda_in.
REQ-003 SHALL have port clk, input, 1, single system clock (25 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port scl_in, input, 1, raw I2C SCL from the pad.
REQ-006 SHALL have port sda_in, input, 1, raw I2C SDA from the pad.
REQ-007 SHALL have port sda_oe, output, 1, open-drain enable; 1 = pull SDA low, 0 = release.
REQ-008 SHALL have port temp_data, input, 16, temperature register value (MSB byte sent first).
REQ-009 SHALL have port busy, output, 1, high from an addressed START until STOP or return to idle.
REQ-010 SHALL have port rd_done, output, 1, one-cycle pulse when the master NACKs a transmitted byte.
REQ-011 SHALL have port wr_data, output, 8, last byte written by the master (see Configuration).
REQ-012 SHALL have port wr_stb, output, 1, one-cycle pulse when wr_data updates.

Function
REQ-013 SHALL synchronize scl_in/sda_in through SYNC_STAGES flops and derive SCL rise/fall pulses and SDA edges from the synchronized values.
REQ-014 SHALL detect START as synced SDA falling while synced SCL high, and STOP as SDA rising while SCL high.
REQ-015 SHALL use states IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK, RX_BYTE, WR_ACK, WAIT_STOP.
REQ-016 SHALL enter ADDR on START from any state (repeated START included), clearing the bit counter.
REQ-017 SHALL sample SDA on each SCL rise in ADDR/RX_BYTE/RX_ACK, MSB first, 8 bits per byte.
REQ-018 SHALL change sda_oe only on the cycle after a detected SCL fall, never while SCL is high.
REQ-019 SHALL, on address match with R/W=1, drive ACK (sda_oe=1) for one SCL period and latch temp_data into a 16-bit shadow at that SCL fall.
REQ-020 SHALL transmit shadow[15:8] then shadow[7:0]; a 1 bit releases SDA, a 0 bit drives sda_oe=1.
REQ-021 SHALL on master ACK after byte 2 wrap to shadow[15:8] without relatching temp_data.
REQ-022 SHALL on master NACK pulse rd_done, release SDA and enter WAIT_STOP.
REQ-023 SHALL on address mismatch release SDA and enter WAIT_STOP without driving any bit.
REQ-024 SHALL on STOP in any state release SDA within 1 cycle, deassert busy and enter IDLE.

Reset
REQ-025 SHALL while rst=0 force state IDLE, sda_oe=0, busy=0, rd_done=0, wr_stb=0, wr_data=8'h00, shadow=16'h0000, synchronizer flops to 1.
REQ-026 SHALL, when rst asserts mid-transaction, release SDA immediately (asynchronously) and ignore the bus until the next START after release.

Configuration
REQ-027 SHALL honor macro I2C_SLAVE_WRITE_EN: when defined, R/W=0 on matching address is ACKed, each received byte ACKed in WR_ACK, stored to wr_data and pulsed on wr_stb.
REQ-028 SHALL, when I2C_SLAVE_WRITE_EN is undefined, NACK R/W=0 on matching address (enter WAIT_STOP), hold wr_data=8'h00, wr_stb=0.

Structure
REQ-029 SHALL take the state enumeration and START/STOP/ACK constants from shared package i2c_pkg, also used by i2c_master.
REQ-030 SHALL implement synchronization and edge/START/STOP detection in sub-module i2c_bus_sync.

Verification
REQ-031 SHALL verify: read at 7'h4B with temp_data=16'h1A80, master ACK then NACK -> bytes 8'h1A, 8'h80 on SDA, rd_done pulses once, busy drops after STOP.
REQ-032 SHALL verify: read at 7'h48 -> sda_oe stays 0 for the whole transfer, busy 0.
REQ-033 SHALL verify: temp_data changes 16'h1A80->16'h2000 during byte 1 -> bytes still 8'h1A, 8'h80; third byte after master ACK is 8'h1A.
REQ-034 SHALL verify: rst pulled low during byte 2 -> sda_oe=0 same cycle; next START at 7'h4B read returns current temp_data.
REQ-035 SHALL verify: write 8'h5C to 7'h4B -> with I2C_SLAVE_WRITE_EN ACK, wr_data=8'h5C, one wr_stb; without it address NACKed, wr_stb never pulses.
REQ-036 SHALL verify: repeated START after address ACK, then read -> restart into ADDR, ACK, correct bytes, no spurious rd_done.
